// File: rtl/osc_pkg.sv
// Shared constants for the polyphonic oscillator bank: wave types, register offsets, LFSR setup.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package osc_pkg;

    // Wave type encodings held in the per-voice WaveType register
    localparam logic [1:0] WAVE_SAW    = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_NOISE  = 2'd3;

    // Register offsets within one voice window
    localparam logic [2:0] OFF_INCR_LO  = 3'd0;
    localparam logic [2:0] OFF_GATE     = 3'd1;
    localparam logic [2:0] OFF_WAVETYPE = 3'd2;
    localparam logic [2:0] OFF_PW       = 3'd3;
    localparam logic [2:0] OFF_INCR_HI  = 3'd4;

    // Address distance between consecutive voice windows
    localparam int VOICE_STRIDE = 8;

    // 16-bit Galois LFSR used by the noise shaper
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // One Galois step: shift right, fold taps in when the bit shifted out is set
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/osc_voice.sv
// One oscillator voice: bus registers, phase accumulator, noise LFSR and registered wave shaper.
// Latency: register write effective next Clock; acc -> sample is 1 Clock.
// Backpressure: none; free-running, writes are accepted whenever wr_en is pulsed.
module osc_voice
    import osc_pkg::*;
#(
    parameter int ACC_W     = 16,
    parameter int OUT_W     = 8,
    parameter int VOICE_IDX = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       off,
    input  logic [7:0]       wdat,
    output logic [7:0]       rdat,
    output logic [OUT_W-1:0] sample,
    output logic             active
);

    logic [7:0]       incr_lo;
    logic [7:0]       incr_hi;
    logic             gate;
    logic [1:0]       wtype;
    logic [7:0]       pw;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] incr;
    logic             carry;
    logic             gate_off_wr;
    logic [15:0]      lfsr;
    logic [OUT_W-1:0] p;
    logic [7:0]       p8;
    logic [OUT_W-1:0] p_sh;
    logic [OUT_W-1:0] noise;
    logic [OUT_W-1:0] shaped;

    assign incr             = ACC_W'({incr_hi, incr_lo});
    assign {carry, acc_sum} = {1'b0, acc} + {1'b0, incr};
    // A gate-close write clears the accumulator on the same edge it commits
    assign gate_off_wr      = wr_en && (off == OFF_GATE) && !wdat[0];
    assign p                = acc[ACC_W-1 -: OUT_W];
    assign p8               = acc[ACC_W-1 -: 8];
    assign p_sh             = p << 1;
    assign active           = gate;

    // Noise takes the top OUT_W LFSR bits; zero-pad when OUT_W exceeds the LFSR width
    if (OUT_W <= 16) begin : g_noise_narrow
        assign noise = lfsr[15 -: OUT_W];
    end else begin : g_noise_wide
        assign noise = {lfsr, (OUT_W-16)'(0)};
    end

    // Host-visible registers, captured on the decoded write strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            incr_lo <= '0;
            incr_hi <= '0;
            gate    <= 1'b0;
            wtype   <= WAVE_SAW;
            pw      <= '0;
        end else if (wr_en) begin
            case (off)
                OFF_INCR_LO:  incr_lo <= wdat;
                OFF_GATE:     gate    <= wdat[0];
                OFF_WAVETYPE: wtype   <= wdat[1:0];
                OFF_PW:       pw      <= wdat;
                OFF_INCR_HI:  incr_hi <= wdat;
                default:      ;
            endcase
        end
    end

    // Readback mux; unused bits and reserved offsets read as zero
    always_comb begin
        rdat = 8'h00;
        case (off)
            OFF_INCR_LO:  rdat = incr_lo;
            OFF_GATE:     rdat = {7'b0, gate};
            OFF_WAVETYPE: rdat = {6'b0, wtype};
            OFF_PW:       rdat = pw;
            OFF_INCR_HI:  rdat = incr_hi;
            default:      rdat = 8'h00;
        endcase
    end

    // Phase accumulator: free-runs with the committed increment while gated, parked at 0 otherwise
    always_ff @(posedge clk) begin
        if (rst || !gate || gate_off_wr) begin
            acc <= '0;
        end else begin
            acc <= acc_sum;
        end
    end

    // Noise LFSR advances once per accumulator wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED ^ 16'(VOICE_IDX);
        end else if (gate && !gate_off_wr && carry) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    // Wave shape selection from the current phase
    always_comb begin
        shaped = '0;
        case (wtype)
            WAVE_SAW:    shaped = p;
            WAVE_SQUARE: shaped = (p8 < pw) ? '1 : '0;
            WAVE_TRI:    shaped = p[OUT_W-1] ? ~p_sh : p_sh;
            WAVE_NOISE:  shaped = noise;
            default:     shaped = '0;
        endcase
    end

    // Shaper output register; a closed gate forces silence
    always_ff @(posedge clk) begin
        if (rst || !gate) begin
            sample <= '0;
        end else begin
            sample <= shaped;
        end
    end

endmodule

// File: rtl/poly_osc_bank.sv
// Multi-voice oscillator bank: bus sync/decode, NUM_VOICES osc_voice instances, averaging mixer.
// Latency: acc -> Waveform 2 Clocks; bus write commits 3 Clocks after BusClock rise; read 1 Clock.
// Backpressure: none; host must hold address/data for 3 Clocks after each BusClock rise.
module poly_osc_bank
    import osc_pkg::*;
#(
    parameter int          NUM_VOICES = 4,
    parameter int          ACC_W      = 16,
    parameter int          OUT_W      = 8,
    parameter logic [15:0] BASE_ADDR  = 16'h0010
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [15:0]           BusAddress,
    inout  wire  [7:0]            BusData,
    input  logic                  BusReadWrite,
    input  logic                  BusClock,
    output logic [OUT_W-1:0]      Waveform,
    output logic [NUM_VOICES-1:0] VoiceActive
);

    localparam int          LOG2N  = $clog2(NUM_VOICES);
    localparam int          VIDX_W = (NUM_VOICES > 1) ? LOG2N : 1;
    localparam int          SUM_W  = OUT_W + LOG2N;
    localparam logic [15:0] MAP_SZ = 16'(VOICE_STRIDE * NUM_VOICES);

    logic              bclk_s1;
    logic              bclk_s2;
    logic              bclk_s3;
    logic              bclk_rise;
    logic [15:0]       rel;
    logic              in_map;
    logic [VIDX_W-1:0] vsel;
    logic [2:0]        off;
    logic              wr_hit;
    logic [7:0]        rd_mux;
    logic              rd_oe;
    logic [7:0]        rd_q;
    logic [SUM_W-1:0]  mix_sum;
    logic [7:0]        voice_rd     [NUM_VOICES];
    logic [OUT_W-1:0]  voice_sample [NUM_VOICES];

    // Address decode: reserved offsets 5..7 are inside the map, they just hold nothing
    assign rel       = BusAddress - BASE_ADDR;
    assign in_map    = (BusAddress >= BASE_ADDR) && (rel < MAP_SZ);
    assign vsel      = rel[3 +: VIDX_W];
    assign off       = rel[2:0];
    assign bclk_rise = bclk_s2 && !bclk_s3;
    assign wr_hit    = bclk_rise && BusReadWrite && in_map;
    assign BusData   = rd_oe ? rd_q : 8'hzz;

    // BusClock is asynchronous: two-flop synchroniser plus one delay flop for edge detection
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_s3 <= 1'b0;
        end else begin
            bclk_s1 <= BusClock;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        osc_voice #(
            .ACC_W     (ACC_W),
            .OUT_W     (OUT_W),
            .VOICE_IDX (v)
        ) u_voice (
            .clk    (Clock),
            .rst    (Reset),
            .wr_en  (wr_hit && (vsel == VIDX_W'(v))),
            .off    (off),
            .wdat   (BusData),
            .rdat   (voice_rd[v]),
            .sample (voice_sample[v]),
            .active (VoiceActive[v])
        );
    end

    // Select the addressed voice's readback byte
    always_comb begin
        rd_mux = 8'h00;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (vsel == VIDX_W'(v)) begin
                rd_mux = voice_rd[v];
            end
        end
    end

    // Registered read drive: bus is only driven for mapped reads
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_oe <= 1'b0;
            rd_q  <= 8'h00;
        end else begin
            rd_oe <= in_map && !BusReadWrite;
            rd_q  <= in_map ? rd_mux : 8'h00;
        end
    end

    // Full-width sum of all voice samples; wide enough that it never overflows
    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            mix_sum = mix_sum + SUM_W'(voice_sample[v]);
        end
    end

    // Mix register: average by dropping the log2(NUM_VOICES) low bits
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Waveform <= '0;
        end else begin
            Waveform <= OUT_W'(mix_sum >> LOG2N);
        end
    end

endmodule
